// File: rtl/secret_feeder_pkg.sv
// Shared types and defaults for the secret accumulator feeder.
// The word width is fixed here because it must match the accumulator it feeds.
package secret_feeder_pkg;

    localparam int FEEDER_WIDTH  = 32;
    localparam int DEFAULT_DEPTH = 4;
    localparam int DEFAULT_CNT_W = 16;

    typedef logic [FEEDER_WIDTH-1:0] word_t;

    typedef struct packed {
        logic  bypass;
        word_t data;
    } entry_t;

    // IDLE presents zero to the accumulator; ISSUE presents the word popped at the last edge.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } issue_state_e;

    function automatic entry_t make_entry(input logic bypass, input word_t data);
        entry_t e;
        e.bypass = bypass;
        e.data   = data;
        return e;
    endfunction

endpackage

// File: rtl/secret_feeder_if.sv
// Upstream handshake plus the accumulator-facing issue bus of the feeder.
// Handshake: a word transfers on a rising clk edge where in_valid && in_ready are both high.
interface secret_feeder_if;
    import secret_feeder_pkg::*;

    logic  in_valid;
    logic  in_ready;
    word_t in_data;
    logic  in_bypass;
    word_t accum_in;
    logic  accum_bypass;
    logic  issue_valid;

    modport master (
        output in_valid,
        output in_data,
        output in_bypass,
        input  in_ready,
        input  accum_in,
        input  accum_bypass,
        input  issue_valid
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_bypass,
        output in_ready,
        output accum_in,
        output accum_bypass,
        output issue_valid
    );

endinterface

// File: rtl/secret_feeder_fifo.sv
// Synchronous DEPTH-entry FIFO of entry_t with combinational head; no fall-through,
// so a word pushed at an edge is only visible at the head after that edge.
module secret_feeder_fifo
    import secret_feeder_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  entry_t                 push_entry,
    input  logic                   pop,
    output entry_t                 head_entry,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               do_push;
    logic               do_pop;

    always_comb begin
        full     = (level_q == LVL_W'(DEPTH));
        empty    = (level_q == '0);
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        // DEPTH is a power of two, so pointer overflow is the modulo-DEPTH wrap.
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (do_push && !do_pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (do_pop && !do_push) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    assign head_entry = mem_q[rd_ptr_q];
    assign level      = level_q;

endmodule

// File: rtl/secret_feeder.sv
// Buffers upstream words and issues at most one per cycle to the secret accumulator,
// driving zero on idle cycles so the accumulator only adds its internal constant.
module secret_feeder
    import secret_feeder_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int WIDTH = FEEDER_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   hold,
    secret_feeder_if.slave         bus,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic [CNT_W-1:0]       issued_count,
    output issue_state_e           state_dbg
);

    entry_t                 head_entry;
    entry_t                 push_entry;
    logic [$clog2(DEPTH):0] level_w;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   in_ready_w;
    logic                   push_w;
    logic                   pop_w;

    issue_state_e           state_q, state_d;
    logic [WIDTH-1:0]       accum_in_q, accum_in_d;
    logic                   accum_bypass_q, accum_bypass_d;
    logic [CNT_W-1:0]       count_q, count_d;

    secret_feeder_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push_w),
        .push_entry (push_entry),
        .pop        (pop_w),
        .head_entry (head_entry),
        .level      (level_w),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    always_comb begin
        // in_ready looks only at registered occupancy, so a pop at a full edge cannot admit a push.
        in_ready_w     = !fifo_full;
        push_w         = bus.in_valid && in_ready_w;
        push_entry     = make_entry(bus.in_bypass, bus.in_data);
        pop_w          = !fifo_empty && !hold;
        state_d        = ST_IDLE;
        accum_in_d     = '0;
        accum_bypass_d = 1'b0;
        count_d        = count_q;
        if (pop_w) begin
            state_d        = ST_ISSUE;
            accum_in_d     = head_entry.data;
            accum_bypass_d = head_entry.bypass;
            count_d        = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            accum_in_q     <= '0;
            accum_bypass_q <= 1'b0;
            count_q        <= '0;
        end else begin
            state_q        <= state_d;
            accum_in_q     <= accum_in_d;
            accum_bypass_q <= accum_bypass_d;
            count_q        <= count_d;
        end
    end

    assign bus.in_ready     = in_ready_w;
    assign bus.accum_in     = accum_in_q;
    assign bus.accum_bypass = accum_bypass_q;
    assign bus.issue_valid  = (state_q == ST_ISSUE);
    assign fifo_level       = level_w;
    assign issued_count     = count_q;
    assign state_dbg        = state_q;

endmodule

// File: tb/tb_secret_feeder.sv
// Randomised and directed bench for secret_feeder against a queue-based reference model;
// a second instance with a 4-bit issue counter shares the same stimulus.
module tb_secret_feeder;
    import secret_feeder_pkg::*;

    localparam int DEPTH = 4;

    logic clk;
    logic rst;
    logic hold;

    secret_feeder_if bus ();
    secret_feeder_if bus4 ();

    logic [2:0]   fifo_level;
    logic [15:0]  issued_count;
    issue_state_e state_dbg;
    logic [2:0]   fifo_level4;
    logic [3:0]   issued_count4;
    issue_state_e state_dbg4;

    assign bus4.in_valid  = bus.in_valid;
    assign bus4.in_data   = bus.in_data;
    assign bus4.in_bypass = bus.in_bypass;

    secret_feeder #(.DEPTH(DEPTH), .WIDTH(32), .CNT_W(16)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .hold         (hold),
        .bus          (bus.slave),
        .fifo_level   (fifo_level),
        .issued_count (issued_count),
        .state_dbg    (state_dbg)
    );

    secret_feeder #(.DEPTH(DEPTH), .WIDTH(32), .CNT_W(4)) u_dut_w4 (
        .clk          (clk),
        .rst          (rst),
        .hold         (hold),
        .bus          (bus4.slave),
        .fifo_level   (fifo_level4),
        .issued_count (issued_count4),
        .state_dbg    (state_dbg4)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: a plain queue of pending words, updated at each rising edge
    entry_t mq[$];
    int     m_count;
    logic   m_valid;
    word_t  m_data;
    logic   m_byp;
    bit     live = 0;
    bit     m_ready;
    bit     m_pop;
    entry_t m_head;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_count = 0;
            m_valid = 0;
            m_data  = '0;
            m_byp   = 0;
            live    = 1;
        end else if (live) begin
            m_ready = (mq.size() != DEPTH);
            m_pop   = (mq.size() != 0) && !hold;
            if (m_pop) begin
                m_head  = mq.pop_front();
                m_valid = 1;
                m_data  = m_head.data;
                m_byp   = m_head.bypass;
                m_count++;
            end else begin
                m_valid = 0;
                m_data  = '0;
                m_byp   = 0;
            end
            if (bus.in_valid && m_ready) begin
                mq.push_back(make_entry(bus.in_bypass, bus.in_data));
            end
        end
    end

    // scoreboard compare on the falling edge
    always @(negedge clk) begin
        if (live) begin
            check("issue_valid",   {63'd0, bus.issue_valid},  {63'd0, m_valid});
            check("accum_in",      {32'd0, bus.accum_in},     {32'd0, m_data});
            check("accum_bypass",  {63'd0, bus.accum_bypass}, {63'd0, m_byp});
            check("fifo_level",    {61'd0, fifo_level},       64'(mq.size()));
            check("in_ready",      {63'd0, bus.in_ready},     {63'd0, mq.size() != DEPTH});
            check("issued_count",  {48'd0, issued_count},     64'(m_count % 65536));
            check("issued_count4", {60'd0, issued_count4},    64'(m_count % 16));
            check("accum_in_w4",   {32'd0, bus4.accum_in},    {32'd0, m_data});
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        hold = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_bypass = 1'b0;
        bus.in_data = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    int acc;

    initial begin
        rst = 1'b0;
        hold = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_bypass = 1'b0;
        bus.in_data = '0;
        step();

        // 1: reset values and single-word latency
        reset_dut();
        check("rst_level", {61'd0, fifo_level}, 64'd0);
        check("rst_ready", {63'd0, bus.in_ready}, 64'd1);
        check("rst_valid", {63'd0, bus.issue_valid}, 64'd0);
        check("rst_count", {48'd0, issued_count}, 64'd0);
        bus.in_valid = 1'b1;
        bus.in_data = 32'd5;
        step();
        bus.in_valid = 1'b0;
        check("t1_no_fallthru", {63'd0, bus.issue_valid}, 64'd0);
        step();
        check("t1_data", {32'd0, bus.accum_in}, 64'd5);
        check("t1_valid", {63'd0, bus.issue_valid}, 64'd1);
        step();
        check("t1_idle_data", {32'd0, bus.accum_in}, 64'd0);
        check("t1_idle_valid", {63'd0, bus.issue_valid}, 64'd0);
        check("t1_count", {48'd0, issued_count}, 64'd1);

        // 2: fill under hold, refuse when full, drain back-to-back
        reset_dut();
        hold = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data = 32'(i);
            step();
        end
        check("t2_level", {61'd0, fifo_level}, 64'd4);
        check("t2_ready", {63'd0, bus.in_ready}, 64'd0);
        check("t2_accum", {32'd0, bus.accum_in}, 64'd0);
        bus.in_data = 32'd99;
        step();
        check("t2_full_level", {61'd0, fifo_level}, 64'd4);
        bus.in_valid = 1'b0;
        hold = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            check("t2_drain_data", {32'd0, bus.accum_in}, 64'(i));
            check("t2_drain_valid", {63'd0, bus.issue_valid}, 64'd1);
        end
        step();
        check("t2_end_valid", {63'd0, bus.issue_valid}, 64'd0);
        check("t2_count", {48'd0, issued_count}, 64'd4);

        // 3: streaming into an accumulator with constant 7
        reset_dut();
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data = 32'(10 + i);
            step();
            check("t3_level_le1", {63'd0, fifo_level <= 3'd1}, 64'd1);
            if (i >= 1) begin
                check("t3_stream", {32'd0, bus.accum_in}, 64'(10 + i - 1));
                check("t3_stream_valid", {63'd0, bus.issue_valid}, 64'd1);
                acc += int'(bus.accum_in) + 7;
            end
        end
        bus.in_valid = 1'b0;
        step();
        check("t3_last", {32'd0, bus.accum_in}, 64'd19);
        acc += int'(bus.accum_in) + 7;
        check("t3_accum_out", 64'(acc), 64'd215);

        // 4: bypass flag travels with its word
        bus.in_valid = 1'b1;
        bus.in_bypass = 1'b1;
        bus.in_data = 32'hDEAD_BEEF;
        step();
        bus.in_valid = 1'b0;
        bus.in_bypass = 1'b0;
        step();
        check("t4_bypass", {63'd0, bus.accum_bypass}, 64'd1);
        check("t4_data", {32'd0, bus.accum_in}, 64'hDEAD_BEEF);
        step();
        check("t4_bypass_clr", {63'd0, bus.accum_bypass}, 64'd0);

        // 5: reset discards buffered words
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data = 32'h100 + 32'(i);
            step();
        end
        bus.in_valid = 1'b0;
        check("t5_filled", {61'd0, fifo_level}, 64'd3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        hold = 1'b0;
        check("t5_level", {61'd0, fifo_level}, 64'd0);
        check("t5_valid", {63'd0, bus.issue_valid}, 64'd0);
        check("t5_count", {48'd0, issued_count}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t5_no_issue", {63'd0, bus.issue_valid}, 64'd0);
        end

        // 6: counter wrap at 4 bits, pointers wrap repeatedly
        reset_dut();
        for (int i = 0; i < 17; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data = 32'h2000 + 32'(i);
            step();
        end
        bus.in_valid = 1'b0;
        step();
        check("t6_count4", {60'd0, issued_count4}, 64'd1);
        check("t6_count16", {48'd0, issued_count}, 64'd17);

        // randomised traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            bus.in_valid = ($urandom_range(0, 3) != 0);
            hold = ($urandom_range(0, 3) == 0);
            bus.in_data = $urandom;
            bus.in_bypass = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 149) == 0);
            step();
        end
        rst = 1'b0;
        hold = 1'b0;
        bus.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
